// File: rtl/uart_baud_gen.sv
// UART bit-rate generator: frame-based bit ticks (TX at bit start, RX at bit centre).
// Optional 16x oversample tick when BAUD_OVS16_EN is defined; otherwise ovs_tick is tied to 0.
module uart_baud_gen #(
  parameter int CNT_W      = 16,
  parameter int DIV_RST    = 868,
  parameter int FRAME_BITS = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bps_start,
  input  logic             mode,
  input  logic             div_wr,
  input  logic [CNT_W-1:0] div_in,
  output logic             clk_bps,
  output logic [3:0]       bit_cnt,
  output logic             frame_done,
  output logic             busy,
  output logic             ovs_tick
);

  // state | meaning
  // IDLE  | waiting for a rising edge on bps_start; divisor writable
  // RUN   | counting bit periods and issuing clk_bps ticks
  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [3:0]       FRAME_CNT = 4'(FRAME_BITS);
  localparam logic [CNT_W-1:0] DIV_INIT  = CNT_W'(DIV_RST);
  localparam logic [CNT_W-1:0] DIV_MIN   = CNT_W'(2);

  state_t           state, state_nxt;
  logic             bps_start_d;
  logic [CNT_W-1:0] div_reg, div_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       bit_cnt_nxt;
  logic             mode_r, mode_nxt;
  logic             clk_bps_nxt, done_nxt;
  logic             start_ev;
  logic [CNT_W-1:0] target;
  logic [CNT_W-1:0] div_clamped;

  assign start_ev    = bps_start & ~bps_start_d;
  assign target      = mode_r ? (div_reg >> 1) : '0;
  assign div_clamped = (div_in < DIV_MIN) ? DIV_MIN : div_in;
  assign busy        = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bps_start_d <= 1'b0;
      div_reg     <= DIV_INIT;
      cnt         <= '0;
      bit_cnt     <= '0;
      mode_r      <= 1'b0;
      clk_bps     <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state       <= state_nxt;
      bps_start_d <= bps_start;
      div_reg     <= div_nxt;
      cnt         <= cnt_nxt;
      bit_cnt     <= bit_cnt_nxt;
      mode_r      <= mode_nxt;
      clk_bps     <= clk_bps_nxt;
      frame_done  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    div_nxt     = div_reg;
    cnt_nxt     = cnt;
    bit_cnt_nxt = bit_cnt;
    mode_nxt    = mode_r;
    clk_bps_nxt = 1'b0;
    done_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (div_wr) div_nxt = div_clamped;
        if (start_ev) begin
          state_nxt   = RUN;
          cnt_nxt     = '0;
          bit_cnt_nxt = '0;
          mode_nxt    = mode;
        end
      end
      RUN: begin
        if (!bps_start) begin
          // abort: drop straight back with no pulses
          state_nxt   = IDLE;
          cnt_nxt     = '0;
          bit_cnt_nxt = '0;
        end else begin
          cnt_nxt = (cnt == div_reg) ? '0 : cnt + 1'b1;
          if (cnt == target && bit_cnt < FRAME_CNT) begin
            clk_bps_nxt = 1'b1;
            bit_cnt_nxt = bit_cnt + 4'd1;
          end
          if (cnt == div_reg && bit_cnt == FRAME_CNT) begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef BAUD_OVS16_EN
  logic [CNT_W-1:0] ovs_cnt;
  logic [CNT_W-1:0] ovs_top;

  assign ovs_top = div_reg >> 4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovs_cnt  <= '0;
      ovs_tick <= 1'b0;
    end else begin
      ovs_tick <= 1'b0;
      if (state == IDLE && start_ev) begin
        ovs_cnt <= '0;
      end else if (state == RUN && bps_start) begin
        ovs_cnt  <= (ovs_cnt == ovs_top) ? '0 : ovs_cnt + 1'b1;
        ovs_tick <= (ovs_cnt == ovs_top);
      end
    end
  end
`else
  assign ovs_tick = 1'b0;
`endif

endmodule

// File: tb/tb_uart_baud_gen.sv
// Self-checking bench for uart_baud_gen: table-driven frame timing, corner sequences,
// and randomized frames against an arithmetic per-cycle reference model.
module tb_uart_baud_gen;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             bps_start = 1'b0;
  logic             mode = 1'b0;
  logic             div_wr = 1'b0;
  logic [CNT_W-1:0] div_in = '0;
  logic             clk_bps;
  logic [3:0]       bit_cnt;
  logic             frame_done;
  logic             busy;
  logic             ovs_tick;

  int checks = 0;
  int errors = 0;
  int cur_div = 868;

  uart_baud_gen #(.CNT_W(CNT_W), .DIV_RST(868), .FRAME_BITS(10)) dut (
    .clk(clk), .rst_n(rst_n), .bps_start(bps_start), .mode(mode),
    .div_wr(div_wr), .div_in(div_in), .clk_bps(clk_bps), .bit_cnt(bit_cnt),
    .frame_done(frame_done), .busy(busy), .ovs_tick(ovs_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit do_wr;
    int div;
    bit m;
    int first;
    int period;
    int done_at;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clamp(input int v);
    return (v < 2) ? 2 : v;
  endfunction

  task automatic write_div(input int v);
    div_wr = 1'b1;
    div_in = CNT_W'(v);
    @(posedge clk); #1;
    div_wr = 1'b0;
    cur_div = clamp(v);
  endtask

  task automatic release_start();
    bps_start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic idle_check(input int cycles);
    int bad = 0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (busy || clk_bps || frame_done) bad++;
    end
    chk("idle_quiet", bad, 0);
  endtask

  // Measure a whole frame: first tick, tick spacing, tick count, frame_done position.
  task automatic measure(input vec_t v);
    int n = 0, first = -1, prev = -1, gap = -1, bad_gap = 0;
    int ticks = 0, done_at = -1, bc = -1, bz = -1;
    if (v.do_wr) write_div(v.div);
    mode = v.m;
    bps_start = 1'b1;
    @(posedge clk); #1;
    while (done_at < 0 && n < 20000) begin
      @(posedge clk); #1;
      n++;
      if (clk_bps) begin
        if (first < 0) first = n;
        else if (gap < 0) gap = n - prev;
        else if (n - prev != gap) bad_gap++;
        prev = n;
        ticks++;
      end
      if (frame_done) begin
        done_at = n;
        bc = int'(bit_cnt);
        bz = int'(busy);
      end
    end
    chk("tbl_first_tick", first, v.first);
    chk("tbl_period", gap, v.period);
    chk("tbl_gap_var", bad_gap, 0);
    chk("tbl_tick_count", ticks, 10);
    chk("tbl_done_at", done_at, v.done_at);
    chk("tbl_done_bitcnt", bc, 10);
    chk("tbl_done_busy", bz, 0);
    release_start();
  endtask

  // Per-cycle comparison against the frame rules: tick k at 1+target+k*(D+1), done at 10*(D+1).
  task automatic check_frame(input bit m, input int abort_at, input bit wr_start,
                             input int new_div, input int run_wr_at);
    int d, p, tgt, last, k;
    int e_tick, e_bc, e_done, e_busy, e_ovs;
    bit gone;
    if (wr_start) begin
      div_wr = 1'b1;
      div_in = CNT_W'(new_div);
      cur_div = clamp(new_div);
    end
    d = cur_div;
    p = d + 1;
    tgt = m ? d / 2 : 0;
    last = (abort_at > 0) ? abort_at + 2 : 10 * p + 2;
    mode = m;
    bps_start = 1'b1;
    @(posedge clk); #1;
    div_wr = 1'b0;
    mode = ~m;
    for (int n = 0; n <= last; n++) begin
      if (n > 0) begin
        @(posedge clk); #1;
        div_wr = 1'b0;
      end
      gone = (abort_at > 0) && (n >= abort_at);
      k = n - 1 - tgt;
      e_tick = (!gone && k >= 0 && (k % p) == 0 && (k / p) < 10) ? 1 : 0;
      e_bc   = gone ? 0 : (k < 0 ? 0 : ((k / p + 1) > 10 ? 10 : k / p + 1));
      e_done = (!gone && n == 10 * p) ? 1 : 0;
      e_busy = (!gone && n < 10 * p) ? 1 : 0;
`ifdef BAUD_OVS16_EN
      e_ovs  = (!gone && n >= 1 && n <= 10 * p && (n % (d / 16 + 1)) == 0) ? 1 : 0;
`else
      e_ovs  = 0;
`endif
      chk("clk_bps", int'(clk_bps), e_tick);
      chk("bit_cnt", int'(bit_cnt), e_bc);
      chk("frame_done", int'(frame_done), e_done);
      chk("busy", int'(busy), e_busy);
      chk("ovs_tick", int'(ovs_tick), e_ovs);
      if (n == run_wr_at) begin
        div_wr = 1'b1;
        div_in = CNT_W'(100);
      end
      if (abort_at > 0 && n + 1 == abort_at) bps_start = 1'b0;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d, nd, p, ab, rw;
    bit m, ws;

    vecs[0] = '{do_wr: 0, div: 0,   m: 0, first: 1,   period: 869, done_at: 8690};
    vecs[1] = '{do_wr: 0, div: 0,   m: 1, first: 435, period: 869, done_at: 8690};
    vecs[2] = '{do_wr: 1, div: 1,   m: 0, first: 1,   period: 3,   done_at: 30};
    vecs[3] = '{do_wr: 1, div: 0,   m: 1, first: 2,   period: 3,   done_at: 30};
    vecs[4] = '{do_wr: 1, div: 7,   m: 1, first: 4,   period: 8,   done_at: 80};
    vecs[5] = '{do_wr: 1, div: 159, m: 1, first: 80,  period: 160, done_at: 1600};
    vecs[6] = '{do_wr: 1, div: 3,   m: 1, first: 2,   period: 4,   done_at: 40};
    vecs[7] = '{do_wr: 1, div: 2,   m: 0, first: 1,   period: 3,   done_at: 30};

    #12;
    chk("rst_clk_bps", int'(clk_bps), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ovs_tick", int'(ovs_tick), 0);
    chk("rst_bit_cnt", int'(bit_cnt), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) measure(vecs[i]);

    // divisor write while running is ignored; held-high start does not retrigger
    check_frame(1'b0, 0, 1'b0, 0, 5);
    idle_check(20);
    release_start();

    // write and start together: frame runs on the new divisor
    check_frame(1'b1, 0, 1'b1, 11, -1);
    release_start();

    // abort right after the 4th tick (TX, D=11: ticks at 1,13,25,37)
    check_frame(1'b0, 38, 1'b0, 0, -1);
    idle_check(200);

    // oversample spacing at D=159
    write_div(159);
    check_frame(1'b0, 0, 1'b0, 0, -1);
    release_start();

    // asynchronous reset mid-frame
    write_div(20);
    mode = 1'b0;
    bps_start = 1'b1;
    repeat (30) @(posedge clk);
    #3;
    chk("busy_before_rst", int'(busy), 1);
    bps_start = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_clk_bps", int'(clk_bps), 0);
    chk("midrst_frame_done", int'(frame_done), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_ovs_tick", int'(ovs_tick), 0);
    chk("midrst_bit_cnt", int'(bit_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cur_div = 868;
    @(posedge clk); #1;
    idle_check(5);
    check_frame(1'b0, 875, 1'b0, 0, -1);
    release_start();

    for (int r = 0; r < 8; r++) begin
      d = $urandom_range(0, 40);
      write_div(d);
      m  = 1'($urandom_range(0, 1));
      ws = 1'($urandom_range(0, 1));
      nd = $urandom_range(0, 40);
      p  = (ws ? clamp(nd) : cur_div) + 1;
      ab = ($urandom_range(0, 1) == 1) ? $urandom_range(2, 10 * p - 1) : 0;
      rw = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 5) : -1;
      check_frame(m, ab, ws, nd, rw);
      release_start();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
